// File: rtl/block_fetch_buffer.sv
// rtl/block_fetch_buffer.sv - fetches a frame block by block from SRAM into a two-bank block buffer
//
// Ports:
//   Clock, Resetn            clock, asynchronous active-low reset
//   Start                    one-cycle pulse, begins a frame fetch (honoured only when idle)
//   SRAM_address, SRAM_we_n  registered read address; write enable held inactive
//   SRAM_read_data           word for the address presented two cycles earlier
//   Buf_wr_en/address/data   write port into the two-bank buffer (bank*BLOCK_DIM^2 + r*BLOCK_DIM + c)
//   Block_ready              per-bank flag: bank holds a complete block
//   Block_release            per-bank pulse from the consumer freeing a bank
//   Block_count              blocks completely written this frame
//   Done                     one-cycle pulse after the last block's final write
module block_fetch_buffer #(
    parameter int BLOCK_DIM      = 8,
    parameter int ROW_STRIDE     = 320,
    parameter int BASE_ADDR      = 76800,
    parameter int BLOCKS_PER_ROW = 40,
    parameter int BLOCK_ROWS     = 30,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16
) (
    input  logic                                     Clock,
    input  logic                                     Resetn,
    input  logic                                     Start,
    output logic [ADDR_W-1:0]                        SRAM_address,
    input  logic [DATA_W-1:0]                        SRAM_read_data,
    output logic                                     SRAM_we_n,
    output logic                                     Buf_wr_en,
    output logic [$clog2(2*BLOCK_DIM*BLOCK_DIM)-1:0] Buf_wr_address,
    output logic [DATA_W-1:0]                        Buf_wr_data,
    output logic [1:0]                               Block_ready,
    input  logic [1:0]                               Block_release,
    output logic [15:0]                              Block_count,
    output logic                                     Done
);
    localparam int LB    = $clog2(BLOCK_DIM);
    localparam int IW    = 2 * LB;
    localparam int TOTAL = BLOCKS_PER_ROW * BLOCK_ROWS;

    // Address steps; negative intermediate values wrap modulo 2^ADDR_W as intended.
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(ROW_STRIDE - BLOCK_DIM + 1);
    localparam logic [ADDR_W-1:0] BLK_STEP  = ADDR_W'(BLOCK_DIM);
    localparam logic [ADDR_W-1:0] BROW_STEP = ADDR_W'(BLOCK_DIM * ROW_STRIDE - (BLOCKS_PER_ROW - 1) * BLOCK_DIM);

    typedef enum logic [2:0] {IDLE, WAIT_BANK, ISSUE, DRAIN, DONE} state_t;

    state_t            state, next_state;
    logic [IW-1:0]     idx;        // r*BLOCK_DIM + c of the address currently presented
    logic              bank;       // bank of the block being issued / waited for
    logic [ADDR_W-1:0] blk_base;   // SRAM address of sample (0,0) of that block
    logic [15:0]       bx;
    logic [15:0]       blk_num;    // advances when a block's last address is issued
    logic              drain_cnt;
    logic              s1_v;
    logic [IW:0]       s1_addr;

    logic              idx_last, col_last, more_blocks, fill_done, fill_bank;
    logic [ADDR_W-1:0] next_base;

    assign idx_last    = &idx;
    assign col_last    = &idx[LB-1:0];
    assign more_blocks = (blk_num != 16'(TOTAL - 1));
    assign next_base   = (bx == 16'(BLOCKS_PER_ROW - 1)) ? blk_base + BROW_STEP : blk_base + BLK_STEP;
    assign fill_done   = Buf_wr_en && (&Buf_wr_address[IW-1:0]);
    assign fill_bank   = Buf_wr_address[IW];

    assign SRAM_we_n   = 1'b1;
    assign Done        = (state == DONE);
    // Read data arrives in the write cycle itself; gating keeps the port at 0 when idle.
    assign Buf_wr_data = Buf_wr_en ? SRAM_read_data : '0;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (Start) next_state = WAIT_BANK;
            WAIT_BANK: if (!Block_ready[bank]) next_state = ISSUE;
            ISSUE: begin
                // Chain straight into the next block when its bank is already free,
                // letting the current block's last reads drain underneath it.
                if (idx_last) begin
                    if (more_blocks && !Block_ready[~bank]) next_state = ISSUE;
                    else                                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt) next_state = (blk_num == 16'(TOTAL)) ? DONE : WAIT_BANK;
            end
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            SRAM_address   <= '0;
            idx            <= '0;
            bank           <= 1'b0;
            blk_base       <= '0;
            bx             <= '0;
            blk_num        <= '0;
            drain_cnt      <= 1'b0;
            s1_v           <= 1'b0;
            s1_addr        <= '0;
            Buf_wr_en      <= 1'b0;
            Buf_wr_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        blk_base <= BASE;
                        bx       <= '0;
                        blk_num  <= '0;
                        bank     <= 1'b0;
                    end
                end
                WAIT_BANK: begin
                    if (!Block_ready[bank]) begin
                        SRAM_address <= blk_base;
                        idx          <= '0;
                    end
                end
                ISSUE: begin
                    if (!idx_last) begin
                        idx          <= idx + IW'(1);
                        SRAM_address <= SRAM_address + (col_last ? ROW_STEP : COL_STEP);
                    end else begin
                        blk_base  <= next_base;
                        bx        <= (bx == 16'(BLOCKS_PER_ROW - 1)) ? 16'd0 : bx + 16'd1;
                        blk_num   <= blk_num + 16'd1;
                        bank      <= ~bank;
                        drain_cnt <= 1'b0;
                        if (next_state == ISSUE) begin
                            SRAM_address <= next_base;
                            idx          <= '0;
                        end
                    end
                end
                DRAIN:   drain_cnt <= 1'b1;
                default: ;
            endcase
            // Two-stage delay matching the SRAM read latency.
            s1_v           <= (state == ISSUE);
            s1_addr        <= {bank, idx};
            Buf_wr_en      <= s1_v;
            Buf_wr_address <= s1_addr;
        end
    end

    // A completing fill takes priority over a same-edge release of that bank.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Block_ready <= 2'b00;
            Block_count <= '0;
        end else begin
            if (fill_done && !fill_bank)  Block_ready[0] <= 1'b1;
            else if (Block_release[0])    Block_ready[0] <= 1'b0;
            if (fill_done && fill_bank)   Block_ready[1] <= 1'b1;
            else if (Block_release[1])    Block_ready[1] <= 1'b0;
            if (state == IDLE && Start)   Block_count <= '0;
            else if (fill_done)           Block_count <= Block_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_block_fetch_buffer.sv
// tb/tb_block_fetch_buffer.sv - scoreboard bench for block_fetch_buffer
module tb_block_fetch_buffer;
    localparam int A_BD = 8, A_STRIDE = 320, A_BASE = 76800, A_BPR = 40, A_ROWS = 3;
    localparam int A_TOTAL = A_BPR * A_ROWS;
    localparam int B_BD = 4, B_STRIDE = 8, B_BASE = 0, B_BPR = 2, B_ROWS = 1;
    localparam int B_TOTAL = B_BPR * B_ROWS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rstn, a_start, a_we_n, a_wr_en, a_done;
    logic [17:0] a_addr;
    logic [15:0] a_rd, a_wr_data, a_count, a_salt, a_d1;
    logic [6:0]  a_wr_addr;
    logic [1:0]  a_ready, a_rel;

    logic        b_rstn, b_start, b_we_n, b_wr_en, b_done;
    logic [17:0] b_addr;
    logic [15:0] b_rd, b_wr_data, b_count, b_salt, b_d1;
    logic [4:0]  b_wr_addr;
    logic [1:0]  b_ready, b_rel;

    block_fetch_buffer #(.BLOCK_DIM(A_BD), .ROW_STRIDE(A_STRIDE), .BASE_ADDR(A_BASE),
                         .BLOCKS_PER_ROW(A_BPR), .BLOCK_ROWS(A_ROWS), .ADDR_W(18), .DATA_W(16)) dut_a (
        .Clock(clk), .Resetn(a_rstn), .Start(a_start), .SRAM_address(a_addr), .SRAM_read_data(a_rd),
        .SRAM_we_n(a_we_n), .Buf_wr_en(a_wr_en), .Buf_wr_address(a_wr_addr), .Buf_wr_data(a_wr_data),
        .Block_ready(a_ready), .Block_release(a_rel), .Block_count(a_count), .Done(a_done));

    block_fetch_buffer #(.BLOCK_DIM(B_BD), .ROW_STRIDE(B_STRIDE), .BASE_ADDR(B_BASE),
                         .BLOCKS_PER_ROW(B_BPR), .BLOCK_ROWS(B_ROWS), .ADDR_W(18), .DATA_W(16)) dut_b (
        .Clock(clk), .Resetn(b_rstn), .Start(b_start), .SRAM_address(b_addr), .SRAM_read_data(b_rd),
        .SRAM_we_n(b_we_n), .Buf_wr_en(b_wr_en), .Buf_wr_address(b_wr_addr), .Buf_wr_data(b_wr_data),
        .Block_ready(b_ready), .Block_release(b_rel), .Block_count(b_count), .Done(b_done));

    // SRAM models: word = address[15:0] ^ salt, two-cycle read latency.
    always @(posedge clk) begin
        a_d1 <= a_addr[15:0] ^ a_salt;
        a_rd <= a_d1;
        b_d1 <= b_addr[15:0] ^ b_salt;
        b_rd <= b_d1;
    end

    typedef struct {
        int unsigned baddr;
        logic [15:0] data;
        bit          blk_last;
        bit          frame_last;
    } exp_t;

    exp_t a_q[$];
    exp_t b_q[$];
    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int unsigned ref_addr(input int k, input int r, input int c, input int bd,
                                             input int stride, input int base, input int bpr);
        longint unsigned a;
        a = longint'(base) + longint'((k / bpr) * bd + r) * stride + (k % bpr) * bd + c;
        return int'(a % (64'd1 << 18));
    endfunction

    task automatic push_frame(input bit to_b, input int nblk, input int total, input int bd,
                              input int stride, input int base, input int bpr, input bit full,
                              input logic [15:0] salt);
        exp_t e;
        int unsigned a;
        for (int k = 0; k < nblk; k++)
            for (int r = 0; r < bd; r++)
                for (int c = 0; c < bd; c++) begin
                    a            = ref_addr(k, r, c, bd, stride, base, bpr);
                    e.baddr      = (k % 2) * bd * bd + r * bd + c;
                    e.data       = a[15:0] ^ salt;
                    e.blk_last   = (r == bd - 1) && (c == bd - 1);
                    e.frame_last = full && (k == total - 1) && e.blk_last;
                    if (to_b) b_q.push_back(e);
                    else      a_q.push_back(e);
                end
    endtask

    // Monitor A
    int a_exp_count = 0, a_done_seen = 0, a_rdy_bank = 0;
    bit a_rdy_due = 0, a_done_due = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!a_rstn) begin
                a_rdy_due  = 0;
                a_done_due = 0;
            end else begin
                if (a_rdy_due) begin
                    chk("a_ready_set", 32'(a_ready[a_rdy_bank]), 1);
                    chk("a_block_count", 32'(a_count), a_exp_count);
                    a_rdy_due = 0;
                end
                if (a_done_due) begin
                    chk("a_done_pulse", 32'(a_done), 1);
                    a_done_due = 0;
                    a_done_seen++;
                end else if (a_done) begin
                    chk("a_done_unexpected", 32'(a_done), 0);
                end
                if (a_wr_en) begin
                    if (a_q.size() == 0) chk("a_unexpected_write", 32'(a_wr_en), 0);
                    else begin
                        e = a_q.pop_front();
                        chk("a_wr_address", 32'(a_wr_addr), e.baddr);
                        chk("a_wr_data", 32'(a_wr_data), 32'(e.data));
                        if (e.blk_last) begin
                            a_exp_count++;
                            a_rdy_due  = 1;
                            a_rdy_bank = int'(e.baddr / 64);
                        end
                        if (e.frame_last) a_done_due = 1;
                    end
                end
            end
        end
    end

    // Monitor B
    int b_done_seen = 0;
    bit b_done_due = 0, b_finished = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (b_rstn) begin
                if (b_done_due) begin
                    chk("b_done_pulse", 32'(b_done), 1);
                    b_done_due = 0;
                    b_done_seen++;
                end else if (b_done) chk("b_done_unexpected", 32'(b_done), 0);
                if (b_wr_en) begin
                    if (b_q.size() == 0) chk("b_unexpected_write", 32'(b_wr_en), 0);
                    else begin
                        e = b_q.pop_front();
                        chk("b_wr_address", 32'(b_wr_addr), e.baddr);
                        chk("b_wr_data", 32'(b_wr_data), 32'(e.data));
                        if (e.frame_last) b_done_due = 1;
                    end
                end
            end
        end
    end

    // Consumer A: random release delay; optional release aimed at bank 0's completing edge.
    bit a_rel_en = 0, a_collide_en = 0;
    initial begin
        int cnt[2];
        logic [1:0] nx;
        a_rel  = 2'b00;
        cnt[0] = 0;
        cnt[1] = 0;
        forever begin
            @(negedge clk);
            nx = 2'b00;
            for (int b = 0; b < 2; b++)
                if (a_rel_en && a_ready[b]) begin
                    if (cnt[b] == 0) begin
                        nx[b]  = 1'b1;
                        cnt[b] = int'($urandom_range(0, 3));
                    end else cnt[b]--;
                end
            if (a_collide_en && a_wr_en && a_wr_addr == 7'd63 && ($urandom % 2 == 0)) nx[0] = 1'b1;
            a_rel = nx;
        end
    end

    // Consumer B releases as soon as a bank is ready.
    initial begin
        b_rel = 2'b00;
        forever begin
            @(negedge clk);
            b_rel = b_ready;
        end
    end

    task automatic chk_reset_a();
        chk("a_rst_sram_address", 32'(a_addr), 0);
        chk("a_rst_we_n", 32'(a_we_n), 1);
        chk("a_rst_wr_en", 32'(a_wr_en), 0);
        chk("a_rst_wr_address", 32'(a_wr_addr), 0);
        chk("a_rst_wr_data", 32'(a_wr_data), 0);
        chk("a_rst_ready", 32'(a_ready), 0);
        chk("a_rst_count", 32'(a_count), 0);
        chk("a_rst_done", 32'(a_done), 0);
    endtask

    task automatic start_a(input int nblk, input bit full);
        a_exp_count = 0;
        push_frame(0, nblk, A_TOTAL, A_BD, A_STRIDE, A_BASE, A_BPR, full, a_salt);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_done_a(input int target, input int bound);
        for (int i = 0; i < bound && a_done_seen < target; i++) @(negedge clk);
        chk("a_done_wait", a_done_seen, target);
    endtask

    // Instance B: small geometry, one frame.
    initial begin
        b_rstn  = 1'b0;
        b_start = 1'b0;
        b_salt  = 16'($urandom);
        repeat (2) @(negedge clk);
        chk("b_rst_wr_en", 32'(b_wr_en), 0);
        chk("b_rst_done", 32'(b_done), 0);
        b_rstn = 1'b1;
        @(negedge clk);
        push_frame(1, B_TOTAL, B_TOTAL, B_BD, B_STRIDE, B_BASE, B_BPR, 1, b_salt);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 500 && b_done_seen < 1; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("b_done_once", b_done_seen, 1);
        chk("b_queue_empty", b_q.size(), 0);
        chk("b_block_count", 32'(b_count), 2);
        b_finished = 1;
    end

    // Instance A: main scenarios.
    initial begin
        a_rstn  = 1'b0;
        a_start = 1'b0;
        a_salt  = 16'h0000;
        repeat (3) @(negedge clk);
        chk_reset_a();
        a_rstn = 1'b1;
        @(negedge clk);

        // Full frame, SRAM[a] = a[15:0], prompt releases, colliding releases, stray Start.
        a_rel_en     = 1;
        a_collide_en = 1;
        start_a(A_TOTAL, 1);
        repeat (300) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_done_a(1, 20000);
        chk("a_frame_queue_empty", a_q.size(), 0);
        chk("a_frame_count", 32'(a_count), A_TOTAL);
        repeat (30) @(negedge clk);
        chk("a_all_released", 32'(a_ready), 0);
        chk("a_done_once", a_done_seen, 1);

        // Consumer never releases: two blocks, then a parked address.
        a_rel_en     = 0;
        a_collide_en = 0;
        a_salt       = 16'($urandom);
        start_a(2, 0);
        for (int i = 0; i < 1000 && a_q.size() != 0; i++) @(negedge clk);
        chk("a_stuck_two_blocks", a_q.size(), 0);
        for (int i = 0; i < 3; i++) begin
            repeat (25) @(negedge clk);
            chk("a_stuck_address", 32'(a_addr), ref_addr(1, A_BD - 1, A_BD - 1, A_BD, A_STRIDE, A_BASE, A_BPR));
        end
        chk("a_stuck_ready", 32'(a_ready), 3);
        chk("a_stuck_count", 32'(a_count), 2);

        // Reset while stuck, then reset at the 20th ISSUE cycle of a new frame.
        @(posedge clk);
        #2 a_rstn = 1'b0;
        a_q.delete();
        @(negedge clk);
        chk_reset_a();
        a_rstn   = 1'b1;
        a_rel_en = 1;
        a_salt   = 16'($urandom);
        @(negedge clk);
        start_a(A_TOTAL, 1);
        repeat (20) @(posedge clk);
        #2 a_rstn = 1'b0;
        a_q.delete();
        @(negedge clk);
        chk_reset_a();
        repeat (3) @(negedge clk);
        a_rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("a_idle_after_reset", 32'(a_addr), 0);
        start_a(A_TOTAL, 1);
        wait_done_a(2, 20000);
        chk("a_frame2_queue_empty", a_q.size(), 0);
        chk("a_frame2_count", 32'(a_count), A_TOTAL);

        for (int i = 0; i < 1000 && !b_finished; i++) @(negedge clk);
        chk("b_finished", 32'(b_finished), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/block_fetch_buffer.md
BLOCK_FETCH_BUFFER -- requirements
Module: block_fetch_buffer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- BLOCK_DIM, 8, block edge in samples; power of two, 2..16.
- ROW_STRIDE, 320, SRAM words between vertically adjacent samples.
- BASE_ADDR, 76800, SRAM address of sample (0,0) of block 0.
- BLOCKS_PER_ROW, 40, blocks per block-row.
- BLOCK_ROWS, 30, block-rows per frame.
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, sample width.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- Clock  in  1  sole clock; all state changes on its rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse that begins a frame fetch; sampled only in IDLE.
- SRAM_address  out  ADDR_W  registered read address.
- SRAM_read_data  in  DATA_W  word for the address driven two cycles earlier.
- SRAM_we_n  out  1  held at 1; this block never writes SRAM.
- Buf_wr_en  out  1  write strobe to the two-bank block buffer.
- Buf_wr_address  out  log2(2*BLOCK_DIM^2)  bank*BLOCK_DIM^2 + r*BLOCK_DIM + c.
- Buf_wr_data  out  DATA_W  sample to write.
- Block_ready  out  2  per-bank flag: bank holds a complete block.
- Block_release  in  2  per-bank one-cycle pulse from the consumer freeing that bank.
- Block_count  out  16  number of blocks completely written this frame.
- Done  out  1  one-cycle pulse after the last block's final write.

Function
REQ-003 Block k (bx = k mod BLOCKS_PER_ROW, by = k div BLOCKS_PER_ROW) SHALL have sample (r,c) at BASE_ADDR + (by*BLOCK_DIM + r)*ROW_STRIDE + bx*BLOCK_DIM + c, computed modulo 2^ADDR_W.
REQ-004 Within a block, addresses SHALL be issued row-major, c fastest, one per cycle, with no gap cycles between rows.
REQ-005 Blocks SHALL be fetched in ascending k and written to banks alternately, starting with bank 0.
REQ-006 The FSM SHALL have states IDLE, WAIT_BANK, ISSUE, DRAIN, DONE.
REQ-007 IDLE -> WAIT_BANK on Start; Start in any other state SHALL be ignored.
REQ-008 WAIT_BANK -> ISSUE in the cycle the target bank's Block_ready is 0; otherwise the FSM SHALL stay in WAIT_BANK with no address activity.
REQ-009 ISSUE SHALL last exactly BLOCK_DIM^2 cycles, then enter DRAIN.
REQ-010 DRAIN SHALL last 2 cycles while the final reads return, then enter WAIT_BANK for the next block, or DONE after block BLOCKS_PER_ROW*BLOCK_ROWS-1.
REQ-011 The next block's ISSUE SHALL overlap the current DRAIN when the other bank is free, so back-to-back blocks incur no bubble.
REQ-012 Buf_wr_en SHALL assert exactly two cycles after each issued address, with matching Buf_wr_address and Buf_wr_data = SRAM_read_data.
REQ-013 Block_ready[b] SHALL set in the cycle after the block's final buffer write, and Block_count SHALL increment in the same cycle.
REQ-014 Block_release[b] SHALL clear Block_ready[b] on the next edge; a release of a bank not ready SHALL be ignored.
REQ-015 If a release and a fill completion hit the same bank on the same edge, the fill SHALL win and Block_ready[b] SHALL end at 1.
REQ-016 DONE SHALL pulse Done for one cycle, then enter IDLE; Block_ready SHALL keep its state until released.
REQ-017 The address arithmetic SHALL be incremental: add 1 per column, and add ROW_STRIDE-BLOCK_DIM+1 at a row end; no multiplier.

Reset
REQ-018 Resetn low SHALL force IDLE immediately and set SRAM_address=0, SRAM_we_n=1, Buf_wr_en=0, Buf_wr_address=0, Buf_wr_data=0, Block_ready=0, Block_count=0, Done=0.
REQ-019 Reset asserted mid-block SHALL discard all in-flight reads; no buffer write SHALL occur after Resetn falls until a new Start.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Defaults, SRAM[a]=a[15:0], Start, consumer releases immediately -> block 0 bank 0 holds 76800..76807, 77120..77127 ... 79040..79047; block 1 starts at 76808; Done after 1200 blocks.
- Consumer never releases -> exactly 2 blocks written, FSM stuck in WAIT_BANK, SRAM_address static, Block_ready=2'b11, Block_count=2.
- BLOCK_DIM=4, BLOCKS_PER_ROW=2, BLOCK_ROWS=1, ROW_STRIDE=8, BASE_ADDR=0 -> block 1 reads 4..7, 12..15, 20..23, 28..31; Done pulses once.
- Release[0] on the same edge as bank 0 completes -> Block_ready[0] stays 1.
- Resetn pulsed at the 20th ISSUE cycle, then Start -> no stale writes; the first write is to bank 0 at address 0 with data SRAM[76800].
- Start pulsed during ISSUE -> ignored; address sequence unchanged.
